tpu_sequencer: RTL and testbench

//   Parametrised instruction sequencer for the TPU: holds a writable instruction memory,

---
 rtl/tpu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_tpu_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer.sv
// TPU instruction sequencer: writable instruction memory, fetch/decode FSM and control strobes.
// Optional LOOP instruction is compiled in when SEQ_LOOP_EN is defined (otherwise LOOP is a NOP).
module tpu_sequencer #(
  parameter  int INSTR_W        = 16,
  parameter  int OPC_W          = 3,
  parameter  int IMEM_DEPTH     = 8,
  parameter  int COMPUTE_CYCLES = 6,
  localparam int PC_W           = $clog2(IMEM_DEPTH),
  localparam int ADDR_W         = INSTR_W - OPC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic              start,
  input  logic              exec_ready,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]   pc,
  output logic [ADDR_W-1:0] base_address,
  output logic              load_weight,
  output logic              load_input,
  output logic              store,
  output logic              valid
);

  localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  localparam logic [OPC_W-1:0] OP_HALT        = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LOAD_ADDR   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LOAD_WEIGHT = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LOAD_INPUT  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_COMPUTE     = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_STORE       = OPC_W'(5);
`ifdef SEQ_LOOP_EN
  localparam logic [OPC_W-1:0] OP_LOOP        = OPC_W'(6);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXECUTE = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_reg;
  logic [INSTR_W-1:0]  ir_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [INSTR_W-1:0]  imem [IMEM_DEPTH];

  logic [INSTR_W-1:0]  fetch_word;
  logic [OPC_W-1:0]    fetch_opc;
  logic [OPC_W-1:0]    opc;
  logic [ADDR_W-1:0]   operand;
  logic                stall;
  logic                at_last;
  logic                advance;
  logic                jump;

`ifdef SEQ_LOOP_EN
  logic                loop_active_reg;
  logic [3:0]          loop_cnt_reg;
  logic [3:0]          loop_count;
  logic [PC_W-1:0]     jump_target;
`endif

  // Program memory is only writable while the sequencer is not running.
  always_ff @(posedge clk) begin
    if (imem_we && !busy) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  assign fetch_word = imem[pc];
  assign fetch_opc  = fetch_word[INSTR_W-1 -: OPC_W];
  assign opc        = ir_reg[INSTR_W-1 -: OPC_W];
  assign operand    = ir_reg[ADDR_W-1:0];

  always_comb begin
    stall   = (load_weight | load_input | store) & ~exec_ready;
    at_last = (pc == PC_W'(IMEM_DEPTH - 1));
    jump    = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_count  = operand[ADDR_W-1 -: 4];
    jump_target = operand[PC_W-1:0];
    if (state_reg == S_EXECUTE && opc == OP_LOOP) begin
      jump = loop_active_reg ? (loop_cnt_reg != 4'd0) : (loop_count != 4'd0);
    end
`endif
    advance = 1'b0;
    case (state_reg)
      S_EXECUTE: advance = (opc != OP_HALT) && (opc != OP_COMPUTE) && !stall;
      S_COMPUTE: advance = (cnt_reg == '0);
      default:   advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      pc           <= '0;
      ir_reg       <= '0;
      cnt_reg      <= '0;
      base_address <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_weight  <= 1'b0;
      load_input   <= 1'b0;
      store        <= 1'b0;
      valid        <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_active_reg <= 1'b0;
      loop_cnt_reg    <= 4'd0;
`endif
    end else if (advance) begin
      // Instruction retires: drop strobes, then jump, end or step to the next word.
      load_weight <= 1'b0;
      load_input  <= 1'b0;
      store       <= 1'b0;
      valid       <= 1'b0;
      if (state_reg == S_EXECUTE && opc == OP_LOAD_ADDR) begin
        base_address <= operand;
      end
`ifdef SEQ_LOOP_EN
      if (state_reg == S_EXECUTE && opc == OP_LOOP) begin
        if (loop_active_reg) begin
          if (loop_cnt_reg == 4'd0) loop_active_reg <= 1'b0;
          else                      loop_cnt_reg    <= loop_cnt_reg - 4'd1;
        end else if (loop_count != 4'd0) begin
          loop_active_reg <= 1'b1;
          loop_cnt_reg    <= loop_count - 4'd1;
        end
      end
      if (jump) begin
        pc        <= jump_target;
        state_reg <= S_FETCH;
      end else
`endif
      if (at_last) begin
        state_reg <= S_DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        pc        <= pc + PC_W'(1);
        state_reg <= S_FETCH;
      end
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg <= S_FETCH;
            pc        <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_reg      <= fetch_word;
          state_reg   <= S_EXECUTE;
          load_weight <= (fetch_opc == OP_LOAD_WEIGHT);
          load_input  <= (fetch_opc == OP_LOAD_INPUT);
          store       <= (fetch_opc == OP_STORE);
        end
        S_EXECUTE: begin
          // Strobe instructions waiting on exec_ready simply hold here.
          if (opc == OP_HALT) begin
            state_reg <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (opc == OP_COMPUTE) begin
            state_reg <= S_COMPUTE;
            valid     <= 1'b1;
            cnt_reg   <= CNT_W'(COMPUTE_CYCLES - 1);
          end
        end
        S_COMPUTE: cnt_reg <= cnt_reg - CNT_W'(1);
        default:   state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: an instruction-level program interpreter expands
// each run into the expected per-cycle outputs, which are compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_tpu_sequencer;
  localparam int INSTR_W = 16;
  localparam int IMEM_DEPTH = 8;
  localparam int PC_W = 3;
  localparam int ADDR_W = 13;
  localparam int CC = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_we = 1'b0;
  logic [PC_W-1:0] imem_waddr = '0;
  logic [INSTR_W-1:0] imem_wdata = '0;
  logic start = 1'b0;
  logic exec_ready = 1'b0;

  logic busy, done, load_weight, load_input, store, valid;
  logic [PC_W-1:0] pc;
  logic [ADDR_W-1:0] base_address;
  logic busy_1, done_1, load_weight_1, load_input_1, store_1, valid_1;
  logic [PC_W-1:0] pc_1;
  logic [ADDR_W-1:0] base_address_1;

  tpu_sequencer u_dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .start(start), .exec_ready(exec_ready),
    .busy(busy), .done(done), .pc(pc), .base_address(base_address),
    .load_weight(load_weight), .load_input(load_input), .store(store), .valid(valid)
  );

  tpu_sequencer #(.COMPUTE_CYCLES(1)) u_dut_1 (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .start(start), .exec_ready(exec_ready),
    .busy(busy_1), .done(done_1), .pc(pc_1), .base_address(base_address_1),
    .load_weight(load_weight_1), .load_input(load_input_1), .store(store_1), .valid(valid_1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic lw; logic li; logic st; logic vl; logic busy; logic done;
    logic [PC_W-1:0] pc; logic [ADDR_W-1:0] base;
  } obs_t;

  obs_t got;
  assign got = {load_weight, load_input, store, valid, busy, done, pc, base_address};

  obs_t exp_q[$];
  bit   er_q[$];
  logic [INSTR_W-1:0] prog [IMEM_DEPTH];
  logic [ADDR_W-1:0] m_base;
  bit m_la;
  int m_lc;
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] opd);
    return {op, opd};
  endfunction

  function automatic obs_t mk(input bit lw, input bit li, input bit st, input bit vl,
                              input bit b, input bit d, input int p, input logic [ADDR_W-1:0] base);
    obs_t o;
    o = {lw, li, st, vl, b, d, PC_W'(p), base};
    return o;
  endfunction

  function automatic void push(input obs_t o, input bit er);
    exp_q.push_back(o);
    er_q.push_back(er);
  endfunction

  // Interpret prog[] one instruction at a time and expand it into expected cycles.
  task automatic build_trace(input int smin, input int smax);
    int p = 0;
    int guard = 0;
    int k;
    bit fin = 0;
    bit jmp;
    logic [2:0] op;
    logic [12:0] opd;
    exp_q.delete();
    er_q.delete();
    while (!fin && guard < 400) begin
      guard++;
      op = prog[p][15:13];
      opd = prog[p][12:0];
      jmp = 0;
      push(mk(0, 0, 0, 0, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
      case (op)
        3'd0: begin
          push(mk(0, 0, 0, 0, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
          fin = 1;
        end
        3'd1: begin
          push(mk(0, 0, 0, 0, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
          m_base = opd;
        end
        3'd2, 3'd3, 3'd5: begin
          k = $urandom_range(smax, smin);
          repeat (k) push(mk(op == 3'd2, op == 3'd3, op == 3'd5, 0, 1, 0, p, m_base), 1'b0);
          push(mk(op == 3'd2, op == 3'd3, op == 3'd5, 0, 1, 0, p, m_base), 1'b1);
        end
        3'd4: begin
          push(mk(0, 0, 0, 0, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
          repeat (CC) push(mk(0, 0, 0, 1, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
        end
        3'd6: begin
          push(mk(0, 0, 0, 0, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
`ifdef SEQ_LOOP_EN
          if (!m_la) begin
            if (opd[12:9] != 4'd0) begin m_la = 1; m_lc = int'(opd[12:9]) - 1; jmp = 1; end
          end else if (m_lc == 0) begin
            m_la = 0;
          end else begin
            m_lc--; jmp = 1;
          end
`endif
        end
        default: push(mk(0, 0, 0, 0, 1, 0, p, m_base), 1'($urandom_range(0, 1)));
      endcase
      if (!fin) begin
        if (jmp) p = int'(opd[PC_W-1:0]);
        else if (p == IMEM_DEPTH - 1) fin = 1;
        else p++;
      end
    end
    repeat (3) push(mk(0, 0, 0, 0, 0, 1, p, m_base), 1'($urandom_range(0, 1)));
  endtask

  task automatic load_prog();
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = PC_W'(i); imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // Start the program and compare every cycle; also pokes start and imem writes while busy.
  task automatic run_trace(input string name, input bit wr0, input logic [15:0] wdata);
    int bad = 0;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin imem_we = 1'b1; imem_waddr = '0; imem_wdata = wdata; end
    @(negedge clk);
    start = 1'b0; imem_we = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h required %h", name, i, got, exp_q[i]);
      end else begin
        n_pass++;
      end
      exec_ready = er_q[i];
      start = exp_q[i].busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (exp_q[i].busy && i == 2) begin
        imem_we = 1'b1; imem_waddr = PC_W'($urandom); imem_wdata = INSTR_W'($urandom);
      end else begin
        imem_we = 1'b0;
      end
      @(negedge clk);
    end
    exec_ready = 1'b0; start = 1'b0; imem_we = 1'b0;
    $display("%s: %0d cycles compared, %0d bad", name, exp_q.size(), bad);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (got !== obs_t'(0)) $display("FAIL reset_state: got %h required %h", got, obs_t'(0));
    else n_pass++;
    reset = 1'b0;
    m_base = '0; m_la = 0; m_lc = 0;
    $display("test_reset: outputs %h", got);
  endtask

  task automatic test_compute();
    int c0 = 0, c1 = 0, f0 = -1, f1 = -1, r0 = 0, r1 = 0;
    logic pv0 = 1'b0, pv1 = 1'b0;
    prog[0] = ins(3'd4, 13'd0);
    prog[1] = ins(3'd0, 13'd0);
    for (int i = 2; i < IMEM_DEPTH; i++) prog[i] = ins(3'd7, 13'd0);
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (valid && !pv0) begin r0++; if (f0 < 0) f0 = i; end
      if (valid_1 && !pv1) begin r1++; if (f1 < 0) f1 = i; end
      if (valid) c0++;
      if (valid_1) c1++;
      pv0 = valid; pv1 = valid_1;
      @(negedge clk);
    end
    n_checks += 6;
    if (c0 !== CC) $display("FAIL compute6_len: got %0d required %0d", c0, CC); else n_pass++;
    if (f0 !== 2)  $display("FAIL compute6_first: got %0d required 2", f0); else n_pass++;
    if (r0 !== 1)  $display("FAIL compute6_runs: got %0d required 1", r0); else n_pass++;
    if (c1 !== 1)  $display("FAIL compute1_len: got %0d required 1", c1); else n_pass++;
    if (f1 !== 2)  $display("FAIL compute1_first: got %0d required 2", f1); else n_pass++;
    if ({busy, done, pc} !== {1'b0, 1'b1, 3'd1})
      $display("FAIL compute_halt: got %b required %b", {busy, done, pc}, {1'b0, 1'b1, 3'd1});
    else n_pass++;
    $display("test_compute: valid runs %0d/%0d cycles", c0, c1);
    build_trace(0, 0);
    run_trace("compute_trace", 0, '0);
  endtask

  task automatic test_program();
    prog[0] = ins(3'd1, 13'h0F); prog[1] = ins(3'd2, 13'd0);
    prog[2] = ins(3'd1, 13'h1E); prog[3] = ins(3'd3, 13'd0);
    prog[4] = ins(3'd4, 13'd0);  prog[5] = ins(3'd1, 13'h07);
    prog[6] = ins(3'd5, 13'd0);  prog[7] = ins(3'd0, 13'd0);
    load_prog();
    build_trace(0, 0);
    run_trace("program", 0, '0);
  endtask

  task automatic test_stall();
    prog[0] = ins(3'd3, 13'd0);
    prog[1] = ins(3'd0, 13'd0);
    load_prog();
    build_trace(3, 3);
    run_trace("stall", 0, '0);
  endtask

  task automatic test_implicit_end();
    int ops[6] = '{1, 2, 3, 4, 5, 7};
    for (int i = 0; i < IMEM_DEPTH; i++)
      prog[i] = ins(3'(ops[$urandom_range(0, 5)]), 13'($urandom));
    load_prog();
    build_trace(0, 2);
    run_trace("implicit_end", 0, '0);
    build_trace(0, 2);
    run_trace("implicit_restart", 0, '0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int t = 0;
    prog[0] = ins(3'd1, 13'h55);
    prog[1] = ins(3'd4, 13'd0);
    prog[2] = ins(3'd0, 13'd0);
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (seen < 3 && t < 40) begin
      if (valid) seen++;
      if (seen < 3) @(negedge clk);
      t++;
    end
    n_checks++;
    if (seen < 3) $display("FAIL reset_mid_timeout: got %0d valid cycles required 3", seen);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (got !== obs_t'(0)) $display("FAIL reset_mid_async: got %h required %h", got, obs_t'(0));
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    m_base = '0; m_la = 0; m_lc = 0;
    $display("test_reset_mid: reset after %0d valid cycles", seen);
    build_trace(0, 1);
    run_trace("after_reset", 0, '0);
  endtask

  task automatic test_loop();
    prog[0] = ins(3'd1, 13'h3);
    prog[1] = ins(3'd2, 13'd0);
    prog[2] = ins(3'd7, 13'd0);
    prog[3] = ins(3'd6, {4'd2, 6'd0, 3'd1});
    prog[4] = ins(3'd5, 13'd0);
    prog[5] = ins(3'd0, 13'd0);
    load_prog();
    build_trace(0, 1);
    run_trace("loop", 0, '0);
  endtask

  task automatic test_write_start();
    logic [15:0] w;
    w = ins(3'd1, 13'h0AB);
    prog[0] = w;
    build_trace(0, 1);
    run_trace("write_with_start", 1, w);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        r = $urandom_range(0, 6);
        prog[i] = ins((r == 0 && $urandom_range(0, 2) != 0) ? 3'd7 : (r == 6 ? 3'd7 : 3'(r)),
                      13'($urandom));
      end
      load_prog();
      build_trace(0, 2);
      run_trace($sformatf("random_%0d", n), 0, '0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_compute();
    test_program();
    test_stall();
    test_implicit_end();
    test_reset_mid();
    test_loop();
    test_write_start();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
